keypoint_merge_reader: RTL

- Downstream consumer of the detect/filter stage.
- After detection completes, it reads back the two keypoint SRAMs: layer-1 hits (keypoint_1) and layer-2 hits (keypoint_2). Each entry is {row[8:0], col[9:0]}.
- It merges the two row-major-sorted lists into one raster-ordered stream tagged with layer ID.
- It hands that stream to the descriptor/orientation stage over a valid/ready handshake.

---
 rtl/keypoint_merge_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/keypoint_merge_reader.sv
// Reads back the layer-1 and layer-2 keypoint SRAMs and merges the two row-major
// lists into one raster-ordered, layer-tagged valid/ready stream.
`timescale 1ns/1ps
module keypoint_merge_reader #(
  parameter int ADDR_W = 11,
  parameter int KP_W   = 19,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  kp1_count,
  input  logic [CNT_W-1:0]  kp2_count,
  output logic [ADDR_W-1:0] kp1_addr,
  input  logic [KP_W-1:0]   kp1_dout,
  output logic [ADDR_W-1:0] kp2_addr,
  input  logic [KP_W-1:0]   kp2_dout,
  output logic              kp_out_valid,
  input  logic              kp_out_ready,
  output logic [KP_W:0]     kp_out_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W:0]    emitted
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFETCH, S_LOAD, S_MERGE, S_DRAIN, S_FINISH
  } state_t;

  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(2 ** ADDR_W);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  rem1, rem2;
  logic [KP_W-1:0]   head1, head2;
  logic              head1_valid, head2_valid;
  logic              refill1, refill2;
  logic [CNT_W-1:0]  clamp1, clamp2;
  logic              slot_free, pick_en, pick2, exhausted;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_MAX) ? a : a + ADDR_W'(1);
  endfunction

  always_comb begin
    clamp1    = (kp1_count > MAX_CNT) ? MAX_CNT : kp1_count;
    clamp2    = (kp2_count > MAX_CNT) ? MAX_CNT : kp2_count;
    slot_free = !kp_out_valid || kp_out_ready;
    // a stream that is still refilling blocks the pick so ordering stays exact
    pick_en   = (state == S_MERGE) && slot_free
                && (head1_valid || rem1 == '0) && (head2_valid || rem2 == '0)
                && (head1_valid || head2_valid);
    pick2     = head2_valid && (!head1_valid || (head2 < head1));
    exhausted = (rem1 == '0) && (rem2 == '0) && !head1_valid && !head2_valid;
    busy      = (state != S_IDLE) && (state != S_FINISH);
    done      = (state == S_FINISH);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = (clamp1 == '0 && clamp2 == '0) ? S_FINISH : S_PREFETCH;
      S_PREFETCH: state_nxt = S_LOAD;
      S_LOAD:     state_nxt = S_MERGE;
      S_MERGE:    if (exhausted) state_nxt = S_DRAIN;
      S_DRAIN:    if (!kp_out_valid || kp_out_ready) state_nxt = S_FINISH;
      S_FINISH:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem1         <= '0;
      rem2         <= '0;
      head1        <= '0;
      head2        <= '0;
      head1_valid  <= 1'b0;
      head2_valid  <= 1'b0;
      refill1      <= 1'b0;
      refill2      <= 1'b0;
      kp1_addr     <= '0;
      kp2_addr     <= '0;
      kp_out_valid <= 1'b0;
      kp_out_data  <= '0;
      emitted      <= '0;
    end else begin
      if (kp_out_valid && kp_out_ready) begin
        kp_out_valid <= 1'b0;
        emitted      <= emitted + (CNT_W+1)'(1);
      end
      case (state)
        S_IDLE: if (start) begin
          rem1        <= clamp1;
          rem2        <= clamp2;
          kp1_addr    <= '0;
          kp2_addr    <= '0;
          emitted     <= '0;
          head1_valid <= 1'b0;
          head2_valid <= 1'b0;
          refill1     <= 1'b0;
          refill2     <= 1'b0;
        end
        S_LOAD: begin
          if (rem1 != '0) begin
            head1       <= kp1_dout;
            head1_valid <= 1'b1;
            kp1_addr    <= addr_inc(kp1_addr);
          end
          if (rem2 != '0) begin
            head2       <= kp2_dout;
            head2_valid <= 1'b1;
            kp2_addr    <= addr_inc(kp2_addr);
          end
        end
        S_MERGE: begin
          if (refill1) begin
            head1       <= kp1_dout;
            head1_valid <= 1'b1;
            kp1_addr    <= addr_inc(kp1_addr);
            refill1     <= 1'b0;
          end
          if (refill2) begin
            head2       <= kp2_dout;
            head2_valid <= 1'b1;
            kp2_addr    <= addr_inc(kp2_addr);
            refill2     <= 1'b0;
          end
          if (pick_en) begin
            kp_out_valid <= 1'b1;
            if (pick2) begin
              kp_out_data <= {1'b1, head2};
              head2_valid <= 1'b0;
              rem2        <= rem2 - CNT_W'(1);
              refill2     <= (rem2 != CNT_W'(1));
            end else begin
              kp_out_data <= {1'b0, head1};
              head1_valid <= 1'b0;
              rem1        <= rem1 - CNT_W'(1);
              refill1     <= (rem1 != CNT_W'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
